// File: rtl/alu_pkg.sv
// Shared opcode, width and type definitions for the registered 16-bit ALU.
// Imported by alu_16bit; clock gating is selected with ALU_CLOCK_GATE_EN.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_AND = 3'b010;
    localparam alu_op_t OP_OR  = 3'b011;
    localparam alu_op_t OP_XOR = 3'b100;
    localparam alu_op_t OP_SHL = 3'b101;
    localparam alu_op_t OP_SHR = 3'b110;
    localparam alu_op_t OP_MUL = 3'b111;

endpackage

// File: rtl/clock_gate.sv
// Latch-based glitch-free clock gate: enable captured while clk is low.
// Used by alu_16bit only when ALU_CLOCK_GATE_EN is defined.
module clock_gate (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    always_latch begin
        if (!clk) en_lat = en;
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/alu_16bit.sv
// Registered eight-operation ALU with zero/carry flags and load enable.
// Define ALU_CLOCK_GATE_EN to clock the output registers from a gated clock.
module alu_16bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
    input  logic             enable,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_t            op;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic               shift_big;
    logic [WIDTH-1:0]   next_result;
    logic               next_carry;
    logic               reg_clk;

    assign op        = alu_op_t'(alu_op);
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign prod      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Any shift amount of WIDTH or more clears the result entirely.
    assign shift_big = |b[WIDTH-1:SHW];

    always_comb begin
        next_result = '0;
        next_carry  = 1'b0;
        unique case (op)
            OP_ADD: begin
                next_result = sum[WIDTH-1:0];
                next_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                next_result = diff[WIDTH-1:0];
                next_carry  = diff[WIDTH];
            end
            OP_AND: next_result = a & b;
            OP_OR:  next_result = a | b;
            OP_XOR: next_result = a ^ b;
            OP_SHL: begin
                if (!shift_big) next_result = a << b[SHW-1:0];
            end
            OP_SHR: begin
                if (!shift_big) next_result = a >> b[SHW-1:0];
            end
            OP_MUL: begin
                next_result = prod[WIDTH-1:0];
                next_carry  = |prod[2*WIDTH-1:WIDTH];
            end
            default: begin
                next_result = '0;
                next_carry  = 1'b0;
            end
        endcase
    end

`ifdef ALU_CLOCK_GATE_EN
    // rst is in the gate enable so a reset edge always reaches the flops.
    clock_gate u_clock_gate (
        .clk  (clk),
        .en   (enable | rst),
        .gclk (reg_clk)
    );
`else
    assign reg_clk = clk;
`endif

    always_ff @(posedge reg_clk) begin
        if (rst) begin
            result     <= '0;
            zero_flag  <= 1'b1;
            carry_flag <= 1'b0;
        end else if (enable) begin
            result     <= next_result;
            zero_flag  <= (next_result == '0);
            carry_flag <= next_carry;
        end
    end

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: directed plan vectors plus
// randomized operations scored against an arithmetic reference model.
module tb_alu_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  alu_op;
    logic        enable;
    logic [15:0] result;
    logic        zero_flag;
    logic        carry_flag;

    int errors = 0;
    int checks = 0;

    int unsigned exp_r = 0;
    bit          exp_z = 1'b1;
    bit          exp_c = 1'b0;

    alu_16bit #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .enable     (enable),
        .result     (result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    function automatic void model(input int unsigned ia, input int unsigned ib,
                                  input int op, output int unsigned r,
                                  output bit c);
        longint unsigned p;
        r = 0;
        c = 1'b0;
        case (op)
            0: begin r = (ia + ib) % 65536; c = (ia + ib) > 65535; end
            1: begin r = (ia + 65536 - ib) % 65536; c = ia < ib; end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: r = (ib >= 16) ? 0 : (ia * (1 << ib)) % 65536;
            6: r = (ib >= 16) ? 0 : ia / (1 << ib);
            default: begin
                p = longint'(ia) * longint'(ib);
                r = int'(p % 65536);
                c = p >= 65536;
            end
        endcase
    endfunction

    task automatic step(input logic r, input logic en, input logic [2:0] op,
                        input logic [15:0] ia, input logic [15:0] ib);
        int unsigned mr;
        bit          mc;
        @(negedge clk);
        rst    = r;
        enable = en;
        alu_op = op;
        a      = ia;
        b      = ib;
        @(posedge clk);
        if (r) begin
            exp_r = 0; exp_z = 1'b1; exp_c = 1'b0;
        end else if (en) begin
            model(int'(ia), int'(ib), int'(op), mr, mc);
            exp_r = mr; exp_z = (mr == 0); exp_c = mc;
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 3'b111, 16'hFFFF, 16'hFFFF);
        step(1'b1, 1'b0, 3'b000, 16'h1234, 16'h4321);
        checks++;
        if (result !== 16'd0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset: got r=%0d z=%b c=%b want r=0 z=1 c=0",
                     result, zero_flag, carry_flag);
        end
    endtask

    task automatic test_hold;
        step(1'b0, 1'b0, 3'b000, 16'd1000, 16'd500);
        step(1'b0, 1'b0, 3'b000, 16'd1000, 16'd500);
        checks++;
        if (result !== 16'd0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_reset: got r=%0d z=%b c=%b want r=0 z=1 c=0",
                     result, zero_flag, carry_flag);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z;
        logic        c;
    } vec_t;

    task automatic test_directed;
        vec_t v [15];
        v[0]  = '{3'b000, 16'd1000,  16'd500,   16'd1500,  1'b0, 1'b0};
        v[1]  = '{3'b000, 16'd65000, 16'd1000,  16'd464,   1'b0, 1'b1};
        v[2]  = '{3'b001, 16'd1000,  16'd300,   16'd700,   1'b0, 1'b0};
        v[3]  = '{3'b001, 16'd500,   16'd500,   16'd0,     1'b1, 1'b0};
        v[4]  = '{3'b001, 16'd300,   16'd1000,  16'd64836, 1'b0, 1'b1};
        v[5]  = '{3'b010, 16'hFF00,  16'h0FF0,  16'h0F00,  1'b0, 1'b0};
        v[6]  = '{3'b011, 16'hF000,  16'h0F00,  16'hFF00,  1'b0, 1'b0};
        v[7]  = '{3'b100, 16'hFFFF,  16'hAAAA,  16'h5555,  1'b0, 1'b0};
        v[8]  = '{3'b101, 16'h0001,  16'd4,     16'h0010,  1'b0, 1'b0};
        v[9]  = '{3'b110, 16'h1000,  16'd4,     16'h0100,  1'b0, 1'b0};
        v[10] = '{3'b101, 16'h0001,  16'd16,    16'h0000,  1'b1, 1'b0};
        v[11] = '{3'b111, 16'd100,   16'd200,   16'd20000, 1'b0, 1'b0};
        v[12] = '{3'b111, 16'd1000,  16'd1000,  16'd16960, 1'b0, 1'b1};
        v[13] = '{3'b110, 16'h8000,  16'd15,    16'h0001,  1'b0, 1'b0};
        v[14] = '{3'b110, 16'hFFFF,  16'h0100,  16'h0000,  1'b1, 1'b0};
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, v[i].op, v[i].a, v[i].b);
            checks++;
            if (result !== v[i].r || zero_flag !== v[i].z || carry_flag !== v[i].c) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d: got r=%0d z=%b c=%b want r=%0d z=%b c=%b",
                         i, v[i].op, result, zero_flag, carry_flag,
                         v[i].r, v[i].z, v[i].c);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] held;
        step(1'b0, 1'b1, 3'b000, 16'd7, 16'd8);
        step(1'b0, 1'b1, 3'b111, 16'd300, 16'd300);
        checks++;
        if (result !== exp_r[15:0] || carry_flag !== exp_c) begin
            errors++;
            $display("FAIL back_to_back: got r=%0d c=%b want r=%0d c=%b",
                     result, carry_flag, exp_r[15:0], exp_c);
        end
        held = result;
        a = 16'hFFFF; b = 16'h0001; alu_op = 3'b000;
        #2;
        checks++;
        if (result !== held || carry_flag !== exp_c) begin
            errors++;
            $display("FAIL mid_cycle_change: got r=%0d want r=%0d", result, held);
        end
        step(1'b0, 1'b0, 3'b000, 16'hFFFF, 16'h0001);
        checks++;
        if (result !== held) begin
            errors++;
            $display("FAIL enable_low_hold: got r=%0d want r=%0d", result, held);
        end
        step(1'b1, 1'b1, 3'b000, 16'hFFFF, 16'h0001);
        checks++;
        if (result !== 16'd0 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got r=%0d z=%b c=%b want r=0 z=1 c=0",
                     result, zero_flag, carry_flag);
        end
    endtask

    task automatic test_random;
        logic        r;
        logic        en;
        logic [2:0]  op;
        logic [15:0] ia;
        logic [15:0] ib;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 99) < 4);
            en = ($urandom_range(0, 99) < 80);
            op = 3'($urandom_range(0, 7));
            ia = 16'($urandom);
            ib = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            step(r, en, op, ia, ib);
            checks++;
            if (result !== exp_r[15:0] || zero_flag !== exp_z || carry_flag !== exp_c) begin
                errors++;
                $display("FAIL random[%0d] rst=%b en=%b op=%0d a=%0d b=%0d: got r=%0d z=%b c=%b want r=%0d z=%b c=%b",
                         i, r, en, op, ia, ib, result, zero_flag, carry_flag,
                         exp_r[15:0], exp_z, exp_c);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; alu_op = 3'b000; a = '0; b = '0;
        test_reset();
        test_hold();
        test_directed();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_16bit.md
# alu_16bit

Registered 16-bit, eight-operation ALU with zero and carry flags and an operand-capture enable, sized for the low-power datapath. Operands and opcode are sampled on a rising clock edge. The result and flags appear registered one cycle later. When `enable` is low the output registers hold, and optionally the register clock is gated off.

## Interface
- `WIDTH`, 16: operand and result width. Only 16 is required to be supported.
- `clk`  input  1  rising-edge clock; one clock domain.
- `rst`  input  1  synchronous, active-high reset.
- `a`  input  16  operand A.
- `b`  input  16  operand B; also the shift amount for shift operations.
- `alu_op`  input  3  operation select.
- `enable`  input  1  update enable; when low, result and flags hold.
- `result`  output  16  registered result.
- `zero_flag`  output  1  registered; 1 when the registered result is 0.
- `carry_flag`  output  1  registered carry, borrow or overflow indicator.

## Operation
- `000` ADD: result = (a+b)[15:0]; carry = bit 16 of the 17-bit sum.
- `001` SUB: result = (a−b)[15:0]; carry = borrow, i.e. 1 when a < b (unsigned).
- `010` AND: result = a & b; carry = 0.
- `011` OR: result = a | b; carry = 0.
- `100` XOR: result = a ^ b; carry = 0.
- `101` SHL: logical shift left of a by b[3:0]; result = 0 if b[15:4] ≠ 0; carry = 0.
- `110` SHR: logical (zero-fill) shift right of a by b[3:0]; result = 0 if b[15:4] ≠ 0; carry = 0.
- `111` MUL: unsigned; result = low 16 bits of the 32-bit product; carry = 1 when the upper 16 bits are non-zero.
- Flag rules:
  - zero_flag is computed from the next result value and registered alongside it.
  - All arithmetic is unsigned. There is no signed overflow flag.
- Combinational next-state logic; there is no state machine.

## Timing
- Latency is 1 cycle. Inputs present at rising edge N are visible on the outputs after edge N.
- The block accepts a new operation on every edge where enable=1. Throughput is one operation per cycle.
- enable=0 at an edge: result, zero_flag and carry_flag keep their previous values.
- rst=1 at an edge forces result=0, zero_flag=1, carry_flag=0.
  - rst has priority over enable and over any operation in flight.
  - Deasserting rst takes effect at the next edge; the first valid output appears one edge after that.
- Changing `alu_op` or the operands between edges has no effect on the outputs until the next edge.

## Configuration
- `ALU_CLOCK_GATE_EN` defined:
  - The output registers are clocked by a gated clock from a latch-based clock-gate cell. That cell is enabled by `enable | rst`.
  - rst is included in the gate enable so that reset always reaches the registers.
- `ALU_CLOCK_GATE_EN` not defined:
  - The registers run on free-running `clk`.
  - `enable` acts as a synchronous load enable.
- Externally visible cycle behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` contains:
  - Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL (3-bit).
  - A typedef for the 3-bit opcode.
  - The default width constant.
- Sub-module `clock_gate` holds the latch plus AND gate and has ports clk, en, gclk. It is instantiated only under `ALU_CLOCK_GATE_EN`.
- The top module contains the operation mux, flag logic and output registers.

## Test plan
- Reset and hold:
  - rst=1 for 2 cycles → result=0, zero=1, carry=0.
  - Release rst, then apply ADD 1000+500 with enable=0 → outputs remain at the reset values.
- Addition (enable=1):
  - ADD 1000+500 → result 1500, carry 0 one cycle later.
  - ADD 65000+1000 → result 464, carry 1.
- Subtraction:
  - SUB 1000−300 → 700, carry 0.
  - SUB 500−500 → 0, zero 1.
  - SUB 300−1000 → 64836, carry 1.
- Logic:
  - AND 0xFF00&0x0FF0 → 0x0F00.
  - OR 0xF000|0x0F00 → 0xFF00.
  - XOR 0xFFFF^0xAAAA → 0x5555.
- Shifts:
  - SHL 0x0001 by 4 → 0x0010.
  - SHR 0x1000 by 4 → 0x0100.
  - SHL by 16 → 0x0000, zero 1.
- Multiply:
  - MUL 100×200 → 20000, carry 0.
  - MUL 1000×1000 → 16960, carry 1.
  - Run in both builds, with and without `ALU_CLOCK_GATE_EN` → identical traces.
